// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: N-cycle shift-add multiply and restoring
// divide on operand magnitudes, with sign fixed up as the final step writes the result.
module muldiv_unit #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         flush,
   input  logic [2:0]   funct3,
   input  logic [N-1:0] rs1,
   input  logic [N-1:0] rs2,
   output logic         stall,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam logic [N-1:0] INT_MIN = {1'b1, {(N-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic             neg_q, neg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [N-1:0]     a_q, a_d, b_q, b_d;
   logic [2*N-1:0]   prod_q, prod_d;
   logic [N:0]       rem_q, rem_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic [N-1:0]     result_q, result_d;

   // Operand decode for a new instruction presented in IDLE
   logic             sign_a, sign_b, neg_a, neg_b, div_zero, overflow, special;
   logic [N-1:0]     mag_a, mag_b, special_res;

   assign sign_a   = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) | (funct3 == 3'b110);
   assign sign_b   = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
   assign neg_a    = sign_a & rs1[N-1];
   assign neg_b    = sign_b & rs2[N-1];
   assign mag_a    = neg_a ? -rs1 : rs1;
   assign mag_b    = neg_b ? -rs2 : rs2;
   assign div_zero = funct3[2] & (rs2 == '0);
   assign overflow = funct3[2] & ~funct3[0] & (rs1 == INT_MIN) & (rs2 == '1);
   assign special  = div_zero | overflow;
   assign special_res = div_zero ? (funct3[1] ? rs1 : '1) : (funct3[1] ? '0 : INT_MIN);

   // One iteration step of each algorithm; the multiplier sits in the low half of prod_q
   logic [N:0]       mul_sum, rem_shift, rem_sub, rem_next;
   logic [2*N-1:0]   mul_next, prod_signed;
   logic [N-1:0]     quo_next, quo_signed, rem_signed, final_res;
   logic             rem_ge;

   assign mul_sum     = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, a_q} : '0);
   assign mul_next    = {mul_sum, prod_q[N-1:1]};
   assign rem_shift   = {rem_q[N-1:0], a_q[N-1]};
   assign rem_sub     = rem_shift - {1'b0, b_q};
   assign rem_ge      = rem_shift >= {1'b0, b_q};
   assign rem_next    = rem_ge ? rem_sub : rem_shift;
   assign quo_next    = {a_q[N-2:0], rem_ge};
   assign prod_signed = neg_q ? -mul_next : mul_next;
   assign quo_signed  = neg_q ? -quo_next : quo_next;
   assign rem_signed  = neg_q ? -rem_next[N-1:0] : rem_next[N-1:0];
   assign final_res   = op_q[2] ? (op_q[1] ? rem_signed : quo_signed)
                                : ((op_q[1:0] == 2'b00) ? prod_signed[N-1:0] : prod_signed[2*N-1:N]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= '0;
         neg_q    <= 1'b0;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         prod_q   <= '0;
         rem_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         prod_q   <= prod_d;
         rem_q    <= rem_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start) state_d = special ? DONE : BUSY;
            BUSY:    if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      op_d     = op_q;
      neg_d    = neg_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      prod_d   = prod_q;
      rem_d    = rem_q;
      result_d = result_q;
      if (state_q == IDLE && start && !flush) begin
         op_d   = funct3;
         neg_d  = (funct3[2] & funct3[1]) ? neg_a : (neg_a ^ neg_b);
         cnt_d  = '0;
         a_d    = mag_a;
         b_d    = mag_b;
         prod_d = {{N{1'b0}}, mag_b};
         rem_d  = '0;
         if (special) result_d = special_res;
      end else if (state_q == BUSY && !flush) begin
         cnt_d = cnt_q + 1'b1;
         if (op_q[2]) begin
            a_d   = quo_next;
            rem_d = rem_next;
         end else begin
            prod_d = mul_next;
         end
         if (cnt_q == LAST) result_d = final_res;
      end
   end

   always_comb begin
      stall  = ((state_q == IDLE) & start & ~flush) | (state_q == BUSY);
      busy_d = (state_d == BUSY);
      done_d = (state_d == DONE);
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: result, latency, stall length, flush and reset.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        flush;
   logic [2:0]  funct3;
   logic [31:0] rs1, rs2;
   logic        stall, busy, done;
   logic [31:0] result;

   int n_vec = 0;
   int n_bad = 0;

   muldiv_unit #(.N(32)) dut (
      .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
      .rs1(rs1), .rs2(rs2), .stall(stall), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op from IDLE and follow it to its done pulse
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      int k;
      int stalls;
      bit seen;
      stalls = 0;
      seen   = 1'b0;
      @(negedge clk);
      funct3 = f; rs1 = a; rs2 = b; start = 1'b1;
      for (k = 1; k <= 60; k++) begin
         #1;
         if (stall) stalls++;
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk({tag, " latency"}, k, lat);
      chk({tag, " result"}, result, exp);
      chk({tag, " stall cycles"}, stalls, lat);
      chk({tag, " done seen"}, {31'd0, seen}, 32'd1);
      @(posedge clk);
      #1;
      chk({tag, " done one cycle"}, {31'd0, done}, 32'd0);
      $display("%s f3=%b rs1=%h rs2=%h -> %h (latency %0d)", tag, f, a, b, result, k);
   endtask

   initial begin
      int dones;
      rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'b000; rs1 = '0; rs2 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy", {31'd0, busy}, 32'd0);
      chk("reset done", {31'd0, done}, 32'd0);
      chk("reset result", result, 32'd0);
      chk("reset stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("MUL 7*6",        3'b000, 32'd7,        32'd6,        32'd42,       33);
      run_op("MULHU ff*ff",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
      run_op("MULH -2*3",      3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 33);
      run_op("MULHSU -1*ff",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
      run_op("MUL -1*ff",      3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
      run_op("DIV -7/2",       3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
      run_op("REM -7/2",       3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
      run_op("DIV 7/-2",       3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
      run_op("REM 7/-2",       3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33);
      run_op("DIVU 100/7",     3'b101, 32'd100,      32'd7,        32'd14,       33);
      run_op("REMU 100/7",     3'b111, 32'd100,      32'd7,        32'd2,        33);
      run_op("DIVU 5/0",       3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
      run_op("REM 5/0",        3'b110, 32'd5,        32'd0,        32'd5,        1);
      run_op("DIV 5/0",        3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
      run_op("DIV min/-1",     3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      run_op("REM min/-1",     3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
      run_op("REMU 9/4",       3'b111, 32'd9,        32'd4,        32'd1,        33);

      // Flush a DIV part-way; result must stay at the REMU 9/4 value
      @(negedge clk);
      funct3 = 3'b100; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      #1;
      chk("flush busy", {31'd0, busy}, 32'd0);
      chk("flush done", {31'd0, done}, 32'd0);
      chk("flush stall", {31'd0, stall}, 32'd0);
      chk("flush result", result, 32'd1);
      dones = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) dones++;
      end
      chk("flush no done", dones, 0);
      $display("flush DIV at cycle 10 -> result %h", result);
      run_op("MUL 3*3", 3'b000, 32'd3, 32'd3, 32'd9, 33);

      // Reset in the middle of a MUL
      @(negedge clk);
      funct3 = 3'b000; rs1 = 32'd5; rs2 = 32'd5; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst result", result, 32'd0);
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst hold busy", {31'd0, busy}, 32'd0);
      chk("rst hold done", {31'd0, done}, 32'd0);
      chk("rst hold result", result, 32'd0);
      $display("reset mid-MUL -> busy %b done %b result %h", busy, done, result);
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      run_op("DIVU 9/3", 3'b101, 32'd9, 32'd3, 32'd3, 33);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage.
- Consumes operand values read from the register file and ID/EX pipeline registers.
- Produces a registered result for the EX/MEM pipeline register.
- While computing, drives a stall that deasserts the load enable of upstream pipeline registers (PC, IF/ID, ID/EX).

Parameters:
N, 32, operand and result width in bits; iteration count equals N.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  EX holds a valid M-extension instruction
flush  input  1  kill in-flight operation (branch/jump redirect)
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1  input  N  operand A (dividend / multiplicand)
rs2  input  N  operand B (divisor / multiplier)
stall  output  1  combinational; 1 = hold upstream pipeline registers (load=0)
busy  output  1  registered; 1 while iterating
done  output  1  registered; one-cycle pulse, result valid
result  output  N  registered result, held until next done

Behaviour:
- FSM states: IDLE, BUSY, DONE.
- Reset (async, rst=1): state=IDLE, busy=0, done=0, result=0, iteration counter=0, internal accumulators=0.
- Reset asserted mid-operation discards the operation immediately; no done pulse follows.

IDLE:
- start=1 latches funct3, rs1, rs2.
- Signed ops convert operands to magnitudes and record result sign.
- Normal op: go to BUSY with counter=0.
- Special case: go directly to DONE with the result preloaded.
- start=0: remain in IDLE.

Special cases (single-cycle, bypass BUSY):
- DIV/DIVU, rs2=0: quotient = all ones (0xFFFFFFFF).
- REM/REMU, rs2=0: remainder = rs1.
- DIV, rs1=0x80000000 and rs2=0xFFFFFFFF: quotient = 0x80000000.
- REM, same operands: remainder = 0.

BUSY:
- One shift-add (multiply) or restore-subtract (divide) step per cycle; counter increments.
- After step N-1: go to DONE. Final sign correction and high/low half selection are written into result on that transition.

DONE:
- done=1 and result valid for exactly one cycle, then return to IDLE.
- start is ignored in DONE. A new op needs start=1 in IDLE, so back-to-back M ops lose no cycles beyond the DONE->IDLE step.

Timing and handshake:
- Latency: start sampled in IDLE at edge 0 → done=1 after edge N+1 for normal ops, after edge 1 for special cases.
- stall = (state==IDLE & start & ~flush) | (state==BUSY). stall=0 in DONE, so the pipeline advances and EX/MEM captures result on that edge.

Flush:
- flush=1 in any state forces IDLE on the next edge.
- done is not asserted and result keeps its old value.
- flush dominates start in the same cycle.

Arithmetic:
- MUL: low N bits of the 2N product.
- MULH: high N bits, both operands signed. MULHSU: rs1 signed, rs2 unsigned. MULHU: both unsigned.
- Signed product negated as a 2N-bit value.
- Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
- Accumulators are 2N bits (product) or N+1 bits (partial remainder).

Test Plan:
- MUL rs1=7, rs2=6 → stall high 33 cycles, done pulse at cycle 33, result=42; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULH rs1=0xFFFFFFFE(-2), rs2=3 → 0xFFFFFFFF; MULHSU rs1=-1, rs2=0xFFFFFFFF → 0xFFFFFFFF; MUL same → 0x00000001.
- DIV -7/2 → 0xFFFFFFFD(-3); REM -7/2 → 0xFFFFFFFF(-1); DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/-1 → 0x80000000; all with done at cycle 1 and stall high for one cycle only.
- Start DIV, assert flush at cycle 10 → IDLE next cycle, no done, result unchanged, stall=0; a following MUL 3×3 completes normally with result 9.
- Assert rst at cycle 15 of a MUL → busy=0, done=0, result=0 immediately; with rst held and start=1, no state change; after release, start DIVU 9/3 → result 3.
